eeg_detect_responder: RTL and testbench
=======================================

EEG_DETECT_RESPONDER -- requirements
Module: eeg_detect_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sample width (signed Q8.8).
REQ-002 Parameter FEATURE_COUNT, default 178, samples per classification.
REQ-003 Parameter DETECTION_THRESHOLD, default 16'h0080, seizure decision threshold.
REQ-004 Parameter CONF_SHIFT, default 8, right shift applied to accumulator to form confidence.
REQ-005 Ports, one per line: name direction width meaning:
 clk  in  1  single system clock; all logic on posedge
 reset  in  1  synchronous, active-high reset
 data_valid  in  1  start-classification pulse from initiator
 system_ready  out  1  high when a start will be accepted
 sample_req  out  1  sample read strobe to feature memory
 sample_addr  out  8  sample index 0..FEATURE_COUNT-1
 sample_data  in  DATA_WIDTH  sample returned exactly one cycle after sample_req
 result_valid  out  1  result fields valid
 seizure_detected  out  1  classification result
 detection_confidence  out  16  saturated line-length score
 system_status  out  2  00 IDLE, 01 PROCESSING, 10 DONE, 11 unused

Function
REQ-006 The block SHALL implement states IDLE, PROCESSING, DONE; system_status SHALL encode the current state.
REQ-007 In IDLE, system_ready SHALL be 1; in PROCESSING and DONE it SHALL be 0.
REQ-008 data_valid sampled high in IDLE SHALL move to PROCESSING next cycle, clear result_valid, and clear the accumulator; data_valid in any other state SHALL be ignored.
REQ-009 In PROCESSING, sample_req SHALL be high for FEATURE_COUNT consecutive cycles with sample_addr = 0,1,...,FEATURE_COUNT-1, one address per cycle.
REQ-010 Each sample_data SHALL be captured one cycle after its sample_req; sample 0 only loads the previous-sample register.
REQ-011 For samples k=1..FEATURE_COUNT-1 the accumulator SHALL add |x[k]-x[k-1]| computed at 17-bit signed width; accumulator width SHALL be 24 bits (no overflow for defaults).
REQ-012 After the last sample is accumulated the block SHALL enter DONE for exactly one cycle, then IDLE.
REQ-013 On entering DONE: detection_confidence SHALL be min(acc >> CONF_SHIFT, 16'hFFFF); seizure_detected SHALL be (confidence >= DETECTION_THRESHOLD); result_valid SHALL be 1.
REQ-014 result_valid, seizure_detected, detection_confidence SHALL hold through IDLE until the next accepted data_valid.
REQ-015 Latency: data_valid accepted at cycle 0 -> sample_req cycles 1..FEATURE_COUNT -> DONE and result_valid at cycle FEATURE_COUNT+2 (180 for default).
REQ-016 All outputs SHALL be registered.

Reset
REQ-017 reset high SHALL, at the next clk edge, force IDLE: system_ready=1, system_status=00, sample_req=0, sample_addr=0, result_valid=0, seizure_detected=0, detection_confidence=0, accumulator=0.
REQ-018 reset during PROCESSING SHALL abort without producing a result; sample_req SHALL drop the cycle after reset is sampled.
REQ-019 data_valid coincident with reset SHALL be ignored.

Structure
REQ-020 Package eeg_detect_pkg SHALL hold the state/status enum, ACC_WIDTH=24, and default parameter constants.
REQ-021 One sub-module line_length_acc SHALL hold the previous-sample register, abs-difference, and 24-bit accumulator (clear, load-first, add enables).

Verification
REQ-022 Constant samples 16'h0100 -> result at cycle 180, confidence 16'h0000, seizure_detected 0.
REQ-023 Ramp x[i]=16'h0100+i -> acc 177, confidence 16'h0000, seizure_detected 0.
REQ-024 Alternating 16'h0000/16'h0100 -> acc 45312, confidence 16'h00B1, seizure_detected 1.
REQ-025 Alternating 16'h7FFF/16'h8000 with CONF_SHIFT=0 -> confidence saturates 16'hFFFF, seizure_detected 1; with CONF_SHIFT=8 -> 16'hB0FF.
REQ-026 data_valid pulsed at cycle 50 of PROCESSING -> ignored, result unchanged; reset at cycle 100 -> IDLE next cycle, result_valid 0, no DONE.
REQ-027 Back-to-back: data_valid in first IDLE cycle after DONE -> accepted, result_valid drops next cycle, new result at +180.

Source files
------------

// File: rtl/eeg_detect_pkg.sv
// Shared types and constants for the EEG line-length seizure detector.
package eeg_detect_pkg;

    localparam int unsigned ACC_WIDTH               = 24;
    localparam int unsigned ADDR_WIDTH              = 8;
    localparam int unsigned CONF_WIDTH              = 16;
    localparam int unsigned DEF_DATA_WIDTH          = 16;
    localparam int unsigned DEF_FEATURE_COUNT       = 178;
    localparam logic [15:0] DEF_DETECTION_THRESHOLD = 16'h0080;
    localparam int unsigned DEF_CONF_SHIFT          = 8;

    // Encodings double as the system_status output.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_PROCESSING = 2'b01,
        ST_DONE       = 2'b10
    } state_t;

    function automatic logic [CONF_WIDTH-1:0] saturate_conf(input logic [ACC_WIDTH-1:0] value);
        return (value > ACC_WIDTH'(65535)) ? '1 : value[CONF_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/line_length_acc.sv
// Previous-sample register, 17-bit absolute difference and line-length accumulator.
module line_length_acc
    import eeg_detect_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load_first,
    input  logic                  add,
    input  logic [DATA_WIDTH-1:0] sample,
    output logic [ACC_WIDTH-1:0]  acc_next_c
);

    logic [DATA_WIDTH-1:0] prev;
    logic [ACC_WIDTH-1:0]  acc;
    logic signed [DATA_WIDTH:0] diff;
    logic [DATA_WIDTH:0]   mag;

    // Sign-extend by one bit so the difference of any two samples is exact.
    always_comb begin
        diff = $signed({sample[DATA_WIDTH-1], sample}) - $signed({prev[DATA_WIDTH-1], prev});
        mag  = diff[DATA_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
        acc_next_c = acc;
        if (clear) begin
            acc_next_c = '0;
        end else if (add) begin
            acc_next_c = acc + ACC_WIDTH'(mag);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc  <= '0;
            prev <= '0;
        end else begin
            acc <= acc_next_c;
            if (load_first || add) begin
                prev <= sample;
            end
        end
    end

endmodule

// File: rtl/eeg_detect_responder.sv
// Fetches a feature window, accumulates its line length and reports a thresholded seizure flag.
module eeg_detect_responder
    import eeg_detect_pkg::*;
#(
    parameter int unsigned DATA_WIDTH          = DEF_DATA_WIDTH,
    parameter int unsigned FEATURE_COUNT       = DEF_FEATURE_COUNT,
    parameter logic [15:0] DETECTION_THRESHOLD = DEF_DETECTION_THRESHOLD,
    parameter int unsigned CONF_SHIFT          = DEF_CONF_SHIFT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_valid,
    output logic                  system_ready,
    output logic                  sample_req,
    output logic [7:0]            sample_addr,
    input  logic [DATA_WIDTH-1:0] sample_data,
    output logic                  result_valid,
    output logic                  seizure_detected,
    output logic [15:0]           detection_confidence,
    output logic [1:0]            system_status
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FEATURE_COUNT - 1);

    state_t state, state_nxt;
    logic                  req_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  cap_valid, cap_first, cap_last;
    logic                  clear, load_first, add;
    logic [ACC_WIDTH-1:0]  acc_next_c;
    logic [ACC_WIDTH-1:0]  scaled;
    logic                  result_valid_nxt, seizure_nxt;
    logic [CONF_WIDTH-1:0] conf_nxt;

    line_length_acc #(.DATA_WIDTH(DATA_WIDTH)) u_acc (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .load_first (load_first),
        .add        (add),
        .sample     (sample_data),
        .acc_next_c (acc_next_c)
    );

    // Next state, fetch sequencing and result capture; cap_* marks the cycle sample_data is valid.
    always_comb begin
        state_nxt        = state;
        req_nxt          = sample_req;
        addr_nxt         = sample_addr;
        clear            = 1'b0;
        load_first       = cap_valid && cap_first;
        add              = cap_valid && !cap_first;
        result_valid_nxt = result_valid;
        seizure_nxt      = seizure_detected;
        conf_nxt         = detection_confidence;
        scaled           = acc_next_c >> CONF_SHIFT;

        case (state)
            ST_IDLE: begin
                if (data_valid) begin
                    state_nxt        = ST_PROCESSING;
                    req_nxt          = 1'b1;
                    addr_nxt         = '0;
                    clear            = 1'b1;
                    result_valid_nxt = 1'b0;
                end
            end
            ST_PROCESSING: begin
                if (sample_req) begin
                    if (sample_addr == LAST_ADDR) begin
                        req_nxt  = 1'b0;
                        addr_nxt = '0;
                    end else begin
                        addr_nxt = sample_addr + ADDR_WIDTH'(1);
                    end
                end
                if (cap_valid && cap_last) begin
                    state_nxt        = ST_DONE;
                    conf_nxt         = saturate_conf(scaled);
                    seizure_nxt      = (conf_nxt >= DETECTION_THRESHOLD);
                    result_valid_nxt = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= ST_IDLE;
            system_ready         <= 1'b1;
            sample_req           <= 1'b0;
            sample_addr          <= '0;
            cap_valid            <= 1'b0;
            cap_first            <= 1'b0;
            cap_last             <= 1'b0;
            result_valid         <= 1'b0;
            seizure_detected     <= 1'b0;
            detection_confidence <= '0;
        end else begin
            state                <= state_nxt;
            system_ready         <= (state_nxt == ST_IDLE);
            sample_req           <= req_nxt;
            sample_addr          <= addr_nxt;
            cap_valid            <= sample_req;
            cap_first            <= sample_req && (sample_addr == '0);
            cap_last             <= sample_req && (sample_addr == LAST_ADDR);
            result_valid         <= result_valid_nxt;
            seizure_detected     <= seizure_nxt;
            detection_confidence <= conf_nxt;
        end
    end

    assign system_status = state;

endmodule

// File: tb/tb_eeg_detect_responder.sv
// Directed bench: fixed sample windows with hand-computed line-length results.
module tb_eeg_detect_responder;

    localparam int FC = 178;

    logic        clk;
    logic        reset;
    logic        data_valid;
    logic [15:0] sample_data;

    logic        system_ready, sample_req, result_valid, seizure_detected;
    logic [7:0]  sample_addr;
    logic [15:0] detection_confidence;
    logic [1:0]  system_status;

    logic        system_ready_b, sample_req_b, result_valid_b, seizure_detected_b;
    logic [7:0]  sample_addr_b;
    logic [15:0] detection_confidence_b;
    logic [1:0]  system_status_b;

    logic [15:0] mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    eeg_detect_responder dut (
        .clk                  (clk),
        .reset                (reset),
        .data_valid           (data_valid),
        .system_ready         (system_ready),
        .sample_req           (sample_req),
        .sample_addr          (sample_addr),
        .sample_data          (sample_data),
        .result_valid         (result_valid),
        .seizure_detected     (seizure_detected),
        .detection_confidence (detection_confidence),
        .system_status        (system_status)
    );

    // Unshifted instance runs in lockstep to exercise confidence saturation.
    eeg_detect_responder #(.CONF_SHIFT(0)) dut_sat (
        .clk                  (clk),
        .reset                (reset),
        .data_valid           (data_valid),
        .system_ready         (system_ready_b),
        .sample_req           (sample_req_b),
        .sample_addr          (sample_addr_b),
        .sample_data          (sample_data),
        .result_valid         (result_valid_b),
        .seizure_detected     (seizure_detected_b),
        .detection_confidence (detection_confidence_b),
        .system_status        (system_status_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Feature memory with one-cycle read latency.
    always_ff @(posedge clk) begin
        if (sample_req) sample_data <= mem[sample_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_pattern(input int kind);
        for (int i = 0; i < 256; i++) begin
            case (kind)
                0: mem[i] = 16'h0100;
                1: mem[i] = 16'(16'h0100 + i);
                2: mem[i] = (i % 2 == 1) ? 16'h0100 : 16'h0000;
                default: mem[i] = (i % 2 == 1) ? 16'h8000 : 16'h7FFF;
            endcase
        end
    endtask

    // Starts a classification and waits for the result, a reset abort, or a cycle budget.
    task automatic run_frame(input int dv_at, input int rst_at, output int lat);
        int n;
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        n = 1;
        check_eq("accept_req", 32'(sample_req), 32'd1);
        check_eq("accept_addr", 32'(sample_addr), 32'd0);
        check_eq("accept_status", 32'(system_status), 32'd1);
        check_eq("accept_ready", 32'(system_ready), 32'd0);
        check_eq("accept_result_valid", 32'(result_valid), 32'd0);
        check_eq("lockstep_addr", 32'(sample_addr_b), 32'(sample_addr));
        while (!result_valid && n < 400 && !(rst_at > 0 && n > rst_at)) begin
            if (n == dv_at) data_valid = 1'b1;
            if (n == rst_at) reset = 1'b1;
            @(posedge clk); #1;
            n++;
            data_valid = 1'b0;
            if (n == 2) check_eq("addr_second", 32'(sample_addr), 32'd1);
            if (n == FC) begin
                check_eq("last_req", 32'(sample_req), 32'd1);
                check_eq("last_addr", 32'(sample_addr), 32'(FC - 1));
            end
            if (n == FC + 1) check_eq("req_drop", 32'(sample_req), 32'd0);
        end
        lat = n;
    endtask

    // Checks the DONE cycle, then the hold in the following IDLE cycle.
    task automatic check_done(input string tag, input int lat, input logic [15:0] conf, input logic sd);
        check_eq({tag, "_latency"}, 32'(lat), 32'd180);
        check_eq({tag, "_status_done"}, 32'(system_status), 32'd2);
        check_eq({tag, "_ready_done"}, 32'(system_ready), 32'd0);
        check_eq({tag, "_result_valid"}, 32'(result_valid), 32'd1);
        check_eq({tag, "_confidence"}, 32'(detection_confidence), 32'(conf));
        check_eq({tag, "_seizure"}, 32'(seizure_detected), 32'(sd));
        @(posedge clk); #1;
        check_eq({tag, "_status_idle"}, 32'(system_status), 32'd0);
        check_eq({tag, "_ready_idle"}, 32'(system_ready), 32'd1);
        check_eq({tag, "_valid_hold"}, 32'(result_valid), 32'd1);
        check_eq({tag, "_conf_hold"}, 32'(detection_confidence), 32'(conf));
    endtask

    initial begin
        int lat;
        int seen;
        reset      = 1'b1;
        data_valid = 1'b1;
        load_pattern(0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(system_ready), 32'd1);
        check_eq("rst_status", 32'(system_status), 32'd0);
        check_eq("rst_req", 32'(sample_req), 32'd0);
        check_eq("rst_addr", 32'(sample_addr), 32'd0);
        check_eq("rst_result_valid", 32'(result_valid), 32'd0);
        check_eq("rst_seizure", 32'(seizure_detected), 32'd0);
        check_eq("rst_conf", 32'(detection_confidence), 32'd0);
        reset      = 1'b0;
        data_valid = 1'b0;
        @(posedge clk); #1;

        load_pattern(0);
        run_frame(0, 0, lat);
        check_done("const", lat, 16'h0000, 1'b0);

        load_pattern(1);
        run_frame(0, 0, lat);
        check_done("ramp", lat, 16'h0000, 1'b0);

        load_pattern(2);
        run_frame(50, 0, lat);
        check_done("alt", lat, 16'h00B1, 1'b1);

        // Started in the first IDLE cycle after DONE.
        load_pattern(3);
        run_frame(0, 0, lat);
        check_eq("sat_valid", 32'(result_valid_b), 32'd1);
        check_eq("sat_confidence", 32'(detection_confidence_b), 32'hFFFF);
        check_eq("sat_seizure", 32'(seizure_detected_b), 32'd1);
        check_done("extreme", lat, 16'hB0FF, 1'b1);

        load_pattern(2);
        run_frame(0, 100, lat);
        reset = 1'b0;
        check_eq("abort_cycle", 32'(lat), 32'd101);
        check_eq("abort_status", 32'(system_status), 32'd0);
        check_eq("abort_ready", 32'(system_ready), 32'd1);
        check_eq("abort_req", 32'(sample_req), 32'd0);
        check_eq("abort_result_valid", 32'(result_valid), 32'd0);
        check_eq("abort_conf", 32'(detection_confidence), 32'd0);
        seen = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (result_valid || system_status == 2'b10) seen++;
        end
        check_eq("abort_no_done", 32'(seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
